// File: rtl/pw_trigger_sequencer_pkg.sv
// pw_trigger_seq_pkg: shared states, default widths and table entry type for the trigger sequencer
package pw_trigger_seq_pkg;
  localparam int DELAY_W   = 20;
  localparam int WIDTH_W   = 17;
  localparam int STEP_BITS = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, DELAY = 2'd2, PULSE = 2'd3} state_e;
  typedef struct packed {
    logic [DELAY_W-1:0] delay;
    logic [WIDTH_W-1:0] width;
  } entry_t;
endpackage

// File: rtl/pw_trigger_sequencer_if.sv
// pw_trigger_sequencer_if: control, table-write and status signals of the trigger sequencer
interface pw_trigger_sequencer_if
  import pw_trigger_seq_pkg::*;
#(
  parameter int DW = DELAY_W,
  parameter int WW = WIDTH_W,
  parameter int SB = STEP_BITS
);
  logic          I_match_pulse;
  logic          I_arm;
  logic          I_disarm;
  logic          I_rearm;
  logic [SB-1:0] I_num_steps;
  logic          I_wr_en;
  logic [SB-1:0] I_wr_addr;
  logic [DW-1:0] I_wr_delay;
  logic [WW-1:0] I_wr_width;
  logic          O_trigger;
  logic          O_armed;
  logic          O_busy;
  logic [SB-1:0] O_step;
  logic          O_done_pulse;
  logic          O_overrun;
  logic          O_wr_reject;
  modport master (
    output I_match_pulse, I_arm, I_disarm, I_rearm, I_num_steps, I_wr_en, I_wr_addr, I_wr_delay, I_wr_width,
    input  O_trigger, O_armed, O_busy, O_step, O_done_pulse, O_overrun, O_wr_reject
  );
  modport slave (
    input  I_match_pulse, I_arm, I_disarm, I_rearm, I_num_steps, I_wr_en, I_wr_addr, I_wr_delay, I_wr_width,
    output O_trigger, O_armed, O_busy, O_step, O_done_pulse, O_overrun, O_wr_reject
  );
endinterface

// File: rtl/pw_trigger_sequencer_table.sv
// pw_trigger_seq_table: (delay, width) register file, sync write, async read, async clear
module pw_trigger_seq_table #(
  parameter int DW = 20,
  parameter int WW = 17,
  parameter int SB = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [SB-1:0] waddr,
  input  logic [DW-1:0] wdelay,
  input  logic [WW-1:0] wwidth,
  input  logic [SB-1:0] raddr,
  output logic [DW-1:0] rdelay,
  output logic [WW-1:0] rwidth
);
  localparam int N = 2 ** SB;
  logic [DW-1:0] dly_q [N];
  logic [DW-1:0] dly_d [N];
  logic [WW-1:0] wid_q [N];
  logic [WW-1:0] wid_d [N];
  always_comb begin
    dly_d = dly_q;
    wid_d = wid_q;
    if (we) begin
      dly_d[waddr] = wdelay;
      wid_d[waddr] = wwidth;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dly_q <= '{default: '0};
      wid_q <= '{default: '0};
    end else begin
      dly_q <= dly_d;
      wid_q <= wid_d;
    end
  assign rdelay = dly_q[raddr];
  assign rwidth = wid_q[raddr];
endmodule

// File: rtl/pw_trigger_sequencer.sv
// pw_trigger_sequencer: plays a table of (delay, width) pulses on O_trigger after one armed match
module pw_trigger_sequencer
  import pw_trigger_seq_pkg::*;
#(
  parameter int pTRIGGER_DELAY_WIDTH = DELAY_W,
  parameter int pTRIGGER_WIDTH_WIDTH = WIDTH_W,
  parameter int pSTEP_BITS           = STEP_BITS
) (
  input logic trigger_clk,
  input logic reset_i,
  pw_trigger_sequencer_if.slave bus
);
  localparam int DW = pTRIGGER_DELAY_WIDTH;
  localparam int WW = pTRIGGER_WIDTH_WIDTH;
  localparam int SB = pSTEP_BITS;
  localparam int CW = (DW > WW) ? DW : WW;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SB-1:0] step_q, step_d, last_q, last_d;
  logic          trig_q, trig_d, ovr_q, ovr_d, rej_q, rej_d;
  logic [DW-1:0] dly;
  logic [WW-1:0] wid;
  logic [CW-1:0] wid_e;
  logic          busy, pulse_end, seq_end;
  pw_trigger_seq_table #(.DW(DW), .WW(WW), .SB(SB)) u_table (
    .clk    (trigger_clk),
    .rst    (reset_i),
    .we     (bus.I_wr_en && state_q == IDLE),
    .waddr  (bus.I_wr_addr),
    .wdelay (bus.I_wr_delay),
    .wwidth (bus.I_wr_width),
    .raddr  (step_q),
    .rdelay (dly),
    .rwidth (wid)
  );
  assign busy      = state_q == DELAY || state_q == PULSE;
  assign wid_e     = (wid == '0) ? CW'(1) : CW'(wid);
  assign pulse_end = state_q == PULSE && cnt_q >= wid_e;
  assign seq_end   = pulse_end && step_q == last_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    last_d  = last_q;
    trig_d  = trig_q;
    ovr_d   = (ovr_q && !bus.I_arm) || (bus.I_match_pulse && busy);
    rej_d   = (rej_q && !bus.I_arm) || (bus.I_wr_en && state_q != IDLE);
    if (bus.I_disarm) begin
      state_d = IDLE;
      cnt_d   = '0;
      step_d  = '0;
      trig_d  = 1'b0;
    end else
      case (state_q)
        IDLE:  state_d = bus.I_arm ? ARMED : IDLE;
        ARMED: if (bus.I_match_pulse) begin
          state_d = DELAY;
          cnt_d   = '0;
          step_d  = '0;
          last_d  = bus.I_num_steps;
        end
        DELAY: if (cnt_q == CW'(dly)) begin
          state_d = PULSE;
          trig_d  = 1'b1;
          cnt_d   = CW'(1);
        end else cnt_d = cnt_q + 1'b1;
        PULSE: if (pulse_end) begin
          trig_d  = 1'b0;
          cnt_d   = '0;
          step_d  = seq_end ? '0 : step_q + 1'b1;
          state_d = !seq_end ? DELAY : bus.I_rearm ? ARMED : IDLE;
        end else cnt_d = cnt_q + 1'b1;
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge trigger_clk or posedge reset_i)
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      last_q  <= '0;
      trig_q  <= 1'b0;
      ovr_q   <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      last_q  <= last_d;
      trig_q  <= trig_d;
      ovr_q   <= ovr_d;
      rej_q   <= rej_d;
    end
  assign bus.O_trigger    = trig_q;
  assign bus.O_armed      = state_q == ARMED;
  assign bus.O_busy       = busy;
  assign bus.O_step       = busy ? step_q : '0;
  assign bus.O_done_pulse = seq_end && !bus.I_disarm;
  assign bus.O_overrun    = ovr_q;
  assign bus.O_wr_reject  = rej_q;
endmodule

// File: tb/tb_pw_trigger_sequencer.sv
// tb_pw_trigger_sequencer: directed pulse-train checks with hand-computed trigger patterns
module tb_pw_trigger_sequencer;
  logic trigger_clk = 1'b0;
  logic reset_i = 1'b1;
  int checks = 0;
  int errors = 0;
  pw_trigger_sequencer_if bus ();
  pw_trigger_sequencer dut (.trigger_clk(trigger_clk), .reset_i(reset_i), .bus(bus));
  always #5 trigger_clk = ~trigger_clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(negedge trigger_clk);
  endtask
  task automatic pulse_arm;
    bus.I_arm = 1'b1;
    tick;
    bus.I_arm = 1'b0;
  endtask
  task automatic wr(input logic [2:0] a, input logic [19:0] d, input logic [16:0] w);
    bus.I_wr_en = 1'b1;
    bus.I_wr_addr = a;
    bus.I_wr_delay = d;
    bus.I_wr_width = w;
    tick;
    bus.I_wr_en = 1'b0;
  endtask
  // bit k of pat is O_trigger after edge E0+k; match at k==0 and again at k==m2
  task automatic seq(input string tag, input logic [31:0] pat, input int len, input int m2, input int done_at);
    for (int k = 0; k < len; k++) begin
      bus.I_match_pulse = (k == 0) || (k == m2);
      tick;
      bus.I_match_pulse = 1'b0;
      chk({tag, "_trig"}, {31'd0, bus.O_trigger}, {31'd0, pat[k]});
      chk({tag, "_done"}, {31'd0, bus.O_done_pulse}, {31'd0, k == done_at});
    end
  endtask
  initial begin
    bus.I_match_pulse = 0; bus.I_arm = 0; bus.I_disarm = 0; bus.I_rearm = 0;
    bus.I_num_steps = 0; bus.I_wr_en = 0; bus.I_wr_addr = 0; bus.I_wr_delay = 0; bus.I_wr_width = 0;
    #3;
    chk("rst_trig", bus.O_trigger, 0);
    chk("rst_armed", bus.O_armed, 0);
    chk("rst_busy", bus.O_busy, 0);
    chk("rst_step", bus.O_step, 0);
    chk("rst_done", bus.O_done_pulse, 0);
    chk("rst_ovr", bus.O_overrun, 0);
    chk("rst_rej", bus.O_wr_reject, 0);
    tick; tick;
    reset_i = 1'b0;
    // T1: single entry (3,2)
    wr(0, 3, 2);
    pulse_arm;
    chk("t1_armed", bus.O_armed, 1);
    seq("t1", 32'h30, 7, -1, 5);
    chk("t1_idle", bus.O_armed, 0);
    chk("t1_busy", bus.O_busy, 0);
    // T2: three entries, rearm
    wr(0, 0, 1); wr(1, 2, 4); wr(2, 5, 1);
    bus.I_num_steps = 2;
    bus.I_rearm = 1'b1;
    pulse_arm;
    seq("t2", 32'h81E2, 17, -1, 15);
    chk("t2_armed", bus.O_armed, 1);
    chk("t2_ovr", bus.O_overrun, 0);
    // T3: overrun mid-sequence, clear, then match on the end edge
    seq("t3", 32'h81E2, 17, 3, 15);
    chk("t3_ovr", bus.O_overrun, 1);
    pulse_arm;
    chk("t3_clr", bus.O_overrun, 0);
    chk("t3_armed", bus.O_armed, 1);
    seq("t3b", 32'h81E2, 17, 16, 15);
    chk("t3_end_ovr", bus.O_overrun, 1);
    chk("t3_end_armed", bus.O_armed, 1);
    tick;
    chk("t3_end_busy", bus.O_busy, 0);
    chk("t3_end_trig", bus.O_trigger, 0);
    // T4: disarm during step 1 pulse
    pulse_arm;
    seq("t4", 32'h81E2, 7, -1, -1);
    chk("t4_step", bus.O_step, 1);
    chk("t4_busy", bus.O_busy, 1);
    bus.I_disarm = 1'b1;
    tick;
    bus.I_disarm = 1'b0;
    chk("t4_trig", bus.O_trigger, 0);
    chk("t4_armed", bus.O_armed, 0);
    chk("t4_busy0", bus.O_busy, 0);
    chk("t4_step0", bus.O_step, 0);
    chk("t4_done", bus.O_done_pulse, 0);
    tick;
    chk("t4_trig_hold", bus.O_trigger, 0);
    pulse_arm;
    chk("t4_rearmed", bus.O_armed, 1);
    bus.I_arm = 1'b1; bus.I_disarm = 1'b1;
    tick;
    bus.I_arm = 1'b0; bus.I_disarm = 1'b0;
    chk("t4_arm_disarm", bus.O_armed, 0);
    // T5: write rejected while ARMED, accepted in IDLE
    bus.I_rearm = 1'b0;
    bus.I_num_steps = 0;
    pulse_arm;
    wr(0, 9, 9);
    chk("t5_rej", bus.O_wr_reject, 1);
    seq("t5a", 32'h2, 3, -1, 1);
    chk("t5_idle", bus.O_armed, 0);
    wr(0, 1, 3); wr(1, 0, 0);
    chk("t5_rej_sticky", bus.O_wr_reject, 1);
    bus.I_num_steps = 1;
    pulse_arm;
    chk("t5_rej_clr", bus.O_wr_reject, 0);
    seq("t5b", 32'h5C, 8, -1, 6);
    chk("t5_end_armed", bus.O_armed, 0);
    chk("t5_end_busy", bus.O_busy, 0);
    // T6: async reset mid-pulse
    bus.I_num_steps = 0;
    pulse_arm;
    wr(0, 7, 7);
    chk("t6_rej", bus.O_wr_reject, 1);
    seq("t6", 32'hC, 4, -1, -1);
    #2 reset_i = 1'b1;
    #1;
    chk("t6_trig", bus.O_trigger, 0);
    chk("t6_busy", bus.O_busy, 0);
    chk("t6_armed", bus.O_armed, 0);
    chk("t6_step", bus.O_step, 0);
    chk("t6_rej0", bus.O_wr_reject, 0);
    tick;
    reset_i = 1'b0;
    pulse_arm;
    seq("t6z", 32'h2, 3, -1, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
